// File: rtl/frecuency_divider.sv
// Programmable integer divider: square wave clk (period N) plus one-cycle tick on each clk rise.
// Latency: registered outputs, one clk_100mhz edge from counter state to clk/tick/div_out.
// Backpressure: none; en=0 freezes counter and clk phase, div_load is always accepted.
//
// Ports:
//   clk_100mhz  system clock, rising edge
//   rst         synchronous active-high reset
//   en          count enable
//   div_load    one-cycle request to load div_in (values < 2 clamp to 2)
//   div_in      new divisor
//   clk         divided square wave (registered data output, high H=N>>1 cycles)
//   tick        one-cycle strobe coinciding with each rising edge of clk
//   div_out     divisor currently in effect
//
// Build option: FREQDIV_GLITCHFREE_EN
//   defined   - loads are held pending and applied at the next period wrap,
//               so no shortened or stretched period is ever produced.
//   undefined - loads apply on the next edge and restart the period from cnt=0, clk=0.

module frecuency_divider #(
  parameter int DIV_DEFAULT = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic             clk_100mhz,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
  output logic             clk,
  output logic             tick,
  output logic [CNT_W-1:0] div_out
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
`ifdef FREQDIV_GLITCHFREE_EN
  logic [CNT_W-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
`endif

  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] load_val;
  logic             wrap;

  // div_q is always >= 2, so half >= 1 and half-1 / div_q-1 never underflow.
  assign half     = div_q >> 1;
  assign load_val = (div_in < CNT_W'(2)) ? CNT_W'(2) : div_in;
  assign wrap     = en && (cnt_q == div_q - CNT_W'(1));

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
`ifdef FREQDIV_GLITCHFREE_EN
    pdiv_d = pdiv_q;
    pend_d = pend_q;
`endif

    if (en) begin
      cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
      tick_d = wrap;
      if (wrap)
        clk_d = 1'b1;
      else if (cnt_q == half - CNT_W'(1))
        clk_d = 1'b0;
    end

`ifdef FREQDIV_GLITCHFREE_EN
    // A pending divisor takes over exactly at the wrap edge; that edge still
    // emits its normal rise, and the new half value governs the next period.
    // A load arriving in the same cycle becomes the next pending value.
    if (wrap && pend_q) begin
      div_d  = pdiv_q;
      pend_d = 1'b0;
    end
    if (div_load) begin
      pdiv_d = load_val;
      pend_d = 1'b1;
    end
`else
    // Immediate load: restart the period; the current one is truncated.
    if (div_load) begin
      div_d  = load_val;
      cnt_d  = '0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= CNT_W'(DIV_DEFAULT);
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
`ifdef FREQDIV_GLITCHFREE_EN
      pdiv_q <= '0;
      pend_q <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
`ifdef FREQDIV_GLITCHFREE_EN
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
`endif
    end
  end

  assign clk     = clk_q;
  assign tick    = tick_q;
  assign div_out = div_q;

endmodule

// File: tb/tb_frecuency_divider.sv
module tb_frecuency_divider;

  localparam int DEF = 4;
  localparam int W   = 8;

  logic         clk_100mhz = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         div_load = 1'b0;
  logic [W-1:0] div_in = '0;
  logic         clk;
  logic         tick;
  logic [W-1:0] div_out;

  frecuency_divider #(.DIV_DEFAULT(DEF), .CNT_W(W)) dut (
    .clk_100mhz(clk_100mhz),
    .rst       (rst),
    .en        (en),
    .div_load  (div_load),
    .div_in    (div_in),
    .clk       (clk),
    .tick      (tick),
    .div_out   (div_out)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int tests = 0;
  int errs  = 0;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: position in the period, divisor, and whether we are
  // still in the very first period after a restart (clk held low throughout).
  // Visible clk is high for the first N/2 positions of every later period.
  int m_ph = 0, m_n = DEF, m_pn = 0;
  bit m_first = 1, m_pend = 0, m_tick = 0;
  bit chk_on = 0;

  function automatic int clamp2(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  always @(posedge clk_100mhz) begin
    bit wrap;
    if (rst) begin
      m_ph = 0; m_n = DEF; m_first = 1; m_pend = 0; m_tick = 0;
      chk_on = 1;
    end else begin
      wrap   = en && (m_ph == m_n - 1);
      m_tick = wrap;
      if (en) begin
        m_ph = wrap ? 0 : m_ph + 1;
        if (wrap) m_first = 0;
      end
`ifdef FREQDIV_GLITCHFREE_EN
      if (wrap && m_pend) begin
        m_n = m_pn; m_pend = 0;
      end
      if (div_load) begin
        m_pn = clamp2(int'(div_in)); m_pend = 1;
      end
`else
      if (div_load) begin
        m_n = clamp2(int'(div_in)); m_ph = 0; m_first = 1; m_tick = 0;
      end
`endif
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_100mhz) begin
    if (chk_on) begin
      chk("clk",     int'(clk),     int'(!m_first && (m_ph < m_n / 2)));
      chk("tick",    int'(tick),    int'(m_tick));
      chk("div_out", int'(div_out), m_n);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_100mhz);
  endtask

  task automatic do_reset;
    rst = 1'b1; div_load = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  int pat [1:9];
  int t_lo, t_hi;

  initial begin
    pat[1] = 0; pat[2] = 0; pat[3] = 0; pat[4] = 1; pat[5] = 1;
    pat[6] = 0; pat[7] = 0; pat[8] = 1; pat[9] = 1;

    // Reset state and the canonical N=4 waveform after release.
    en = 1'b1;
    rst = 1'b1;
    cyc(2);
    chk("rst_clk",  int'(clk),     0);
    chk("rst_tick", int'(tick),    0);
    chk("rst_div",  int'(div_out), 4);
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      cyc(1);
      chk("pat_clk",  int'(clk),  pat[k]);
      chk("pat_tick", int'(tick), int'(k % 4 == 0));
    end

    // Load 6 at cnt=1 while N=4.
    do_reset();
    cyc(1);                       // cycle 1: cnt=1
    div_load = 1'b1; div_in = 8'd6;
    cyc(1);                       // cycle 2
    div_load = 1'b0;
`ifdef FREQDIV_GLITCHFREE_EN
    t_lo = 4; t_hi = 10;
`else
    t_lo = 8; t_hi = 14;
    chk("ld6_clk_low", int'(clk), 0);
    chk("ld6_div",     int'(div_out), 6);
`endif
    for (int k = 3; k <= 15; k++) begin
      cyc(1);
      chk("ld6_tick", int'(tick), int'(k == t_lo || k == t_hi));
    end
    chk("ld6_div_end", int'(div_out), 6);

    // Load 5, then clamped loads 0 and 1 (model checks steady state).
    div_load = 1'b1; div_in = 8'd5; cyc(1); div_load = 1'b0;
    cyc(20);
    chk("ld5_div", int'(div_out), 5);
    div_load = 1'b1; div_in = 8'd0; cyc(1); div_load = 1'b0;
    cyc(10);
    chk("ld0_div", int'(div_out), 2);
    div_load = 1'b1; div_in = 8'd1; cyc(1); div_load = 1'b0;
    cyc(10);
    chk("ld1_div", int'(div_out), 2);

    // Freeze mid-period for 7 cycles.
    div_load = 1'b1; div_in = 8'd9; cyc(1); div_load = 1'b0;
    cyc(12);
    en = 1'b0; cyc(7); en = 1'b1;
    cyc(20);

    // Reset in the high phase with a load pending: the load is lost.
    div_load = 1'b1; div_in = 8'd7; cyc(1); div_load = 1'b0;
    t_lo = 0;
    while (!clk && t_lo < 40) begin cyc(1); t_lo++; end
    chk("found_high", int'(clk), 1);
    div_load = 1'b1; div_in = 8'd11;
    rst = 1'b1; cyc(1);
    rst = 1'b0; div_load = 1'b0;
    chk("rstmid_clk",  int'(clk),  0);
    chk("rstmid_tick", int'(tick), 0);
    chk("rstmid_div",  int'(div_out), 4);
    cyc(12);
    chk("rstmid_div_after", int'(div_out), 4);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      div_load = ($urandom_range(0, 39) == 0);
      div_in   = W'($urandom_range(0, 12));
      rst      = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0; div_load = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/frecuency_divider.md
# frecuency_divider

Programmable integer clock-enable/clock divider driven from the 100 MHz board clock. Produces a slow square-wave `clk` and a one-cycle `tick` strobe for the train-controller logic, with a runtime-loadable divisor. All logic runs in the `clk_100mhz` domain. `clk` is a registered data output, not a regenerated clock.

## Interface
- `DIV_DEFAULT`, 100_000_000: divisor N after reset (1 Hz from 100 MHz); must be ≥ 2.
- `CNT_W`, 27: width of counter and divisor registers; must hold DIV_DEFAULT−1.

One clock; reset is synchronous and active-high.
- `clk_100mhz`  in  1: system clock, rising-edge.
- `rst`  in  1: synchronous active-high reset.
- `en`  in  1: count enable; low freezes the divider.
- `div_load`  in  1: single-cycle request to load `div_in`.
- `div_in`  in  CNT_W: new divisor value.
- `clk`  out  1: divided square wave, period N input cycles.
- `tick`  out  1: one-cycle pulse coinciding with each rising edge of `clk`.
- `div_out`  out  CNT_W: divisor currently in effect.

## Operation
- State: `cnt` (0..N−1), active divisor N, half value H = N>>1, pending divisor P with pending flag.
- Reset: cnt=0, clk=0, tick=0, N=DIV_DEFAULT, pending flag cleared.
- Enabled cycle:
  - cnt ← (cnt==N−1) ? 0 : cnt+1.
  - clk ← 1 if cnt==N−1; else 0 if cnt==H−1; else hold.
  - tick ← (cnt==N−1).
- Result: clk is high for H cycles and low for N−H cycles. Odd N gives the longer phase low.
- `en`=0: cnt and clk hold, tick=0. The `div_load` capture still occurs.
- Load: a `div_in` value < 2 is clamped to 2. Application timing depends on the configuration macro.
- Multiple loads before application: the last one wins.
- `div_load` asserted together with `rst`: rst wins and the load is discarded.
- Counter arithmetic is unsigned CNT_W-bit. cnt never exceeds N−1. The wrap is exact with no overflow path.

## Timing
- After reset release with en=1: clk and tick first rise on the Nth edge, i.e. visible in cycle N. Subsequent rising edges follow every N cycles.
- tick and clk rise on the same edge. tick lasts exactly one cycle.
- `div_out` updates on the same edge at which the new N takes effect.
- Reset asserted mid-period: all outputs return to reset values on the next edge.

## Configuration
- `FREQDIV_GLITCHFREE_EN` defined:
  - A load stores P and sets the pending flag.
  - P becomes N at the wrap edge (cnt==N−1, enabled). That edge still produces the normal rising clk and tick.
  - No shortened or stretched period is ever emitted.
- Not defined:
  - A load applies N on the next edge, forces cnt=0 and clk=0, and gives tick=0.
  - The first rising edge follows N cycles later. The period containing the load is truncated.

## Test plan
- Reset with DIV_DEFAULT overridden to 4, en=1 -> clk pattern after reset is 0,0,0,1,1,0,0,1,1,…; tick high in cycles 4, 8, 12; div_out=4.
- Load div_in=5 -> steady state is clk high 2 cycles, low 3 cycles; tick every 5 cycles; div_out=5.
- Load div_in=0 and div_in=1 -> div_out=2; clk toggles every cycle; tick every 2 cycles.
- Drop en for 7 cycles mid-period -> cnt and clk frozen, tick=0; the period resumes from the same phase and is stretched by exactly 7 cycles.
- Load 6 at cnt=1 while N=4:
  - with `FREQDIV_GLITCHFREE_EN`: the current 4-cycle period completes, then 6-cycle periods follow.
  - without it: clk=0 next cycle, and the first rising edge comes 6 cycles later.
- Assert rst mid-high-phase while a load is pending -> next cycle clk=0, tick=0, div_out=DIV_DEFAULT; the pending load is lost.
